// File: rtl/nand_spi_die_router.sv
// rtl/nand_spi_die_router.sv - SPI NAND multi-die router with software die select decode
// Optional per-die completed-frame counters: NAND_DIE_STAT_EN
module nand_spi_die_router #(
    parameter int         NUM_DIE    = 2,
    parameter int         DIE_ID_W   = 2,
    parameter int         DEF_DIE    = 0,
    parameter logic [7:0] DIE_SEL_OP = 8'hC2
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    CS_N,
    input  logic                    SCK,
    input  logic                    SI,
    output logic                    SO,
    output logic [NUM_DIE-1:0]      DIE_CS_N,
    input  logic [NUM_DIE-1:0]      DIE_SO,
    output logic [DIE_ID_W-1:0]     ACTIVE_DIE,
    output logic                    SEL_ERR,
    output logic [16*NUM_DIE-1:0]   FRAME_CNT
);

    typedef enum logic [2:0] {ST_IDLE, ST_OPC, ST_ARG, ST_CHK, ST_SKIP} state_t;

    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic si_meta_q, si_sync_q;

    state_t              state_q, state_d;
    logic [7:0]          shift_q, shift_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [DIE_ID_W-1:0] id_q, id_d;
    logic                id_ok_q, id_ok_d;
    logic [DIE_ID_W-1:0] active_q, active_d;
    logic                sel_err_q, sel_err_d;

    logic       sck_rise, cs_rise;
    logic [7:0] byte_now;
    logic       so_sel;

    // A frame end and an SCK edge seen in the same sample: the frame end wins
    assign sck_rise = sck_sync_q & ~sck_prev_q & ~cs_sync_q;
    assign cs_rise  = cs_sync_q & ~cs_prev_q;
    assign byte_now = {shift_q[6:0], si_sync_q};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        id_d      = id_q;
        id_ok_d   = id_ok_q;
        active_d  = active_q;
        sel_err_d = 1'b0;
        if (sck_rise) begin
            shift_d = byte_now;
            if (bit_cnt_q != 5'd17) bit_cnt_d = bit_cnt_q + 5'd1;
        end
        unique case (state_q)
            ST_IDLE: if (!cs_sync_q) begin
                state_d   = ST_OPC;
                bit_cnt_d = {4'b0, sck_rise};
            end
            ST_OPC: if (sck_rise && bit_cnt_q == 5'd7)
                state_d = (byte_now == DIE_SEL_OP) ? ST_ARG : ST_SKIP;
            ST_ARG: if (sck_rise && bit_cnt_q == 5'd15) begin
                id_d    = byte_now[DIE_ID_W-1:0];
                // Any byte below NUM_DIE necessarily has its upper bits clear
                id_ok_d = (byte_now < 8'(NUM_DIE));
                state_d = ST_CHK;
            end
            ST_CHK:  if (sck_rise) state_d = ST_SKIP;
            ST_SKIP: state_d = ST_SKIP;
            default: state_d = ST_IDLE;
        endcase
        if (cs_rise) begin
            state_d = ST_IDLE;
            if (state_q == ST_CHK) begin
                if (id_ok_q) active_d = id_q;
                else         sel_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_meta_q  <= 1'b1;
            cs_sync_q  <= 1'b1;
            cs_prev_q  <= 1'b1;
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            si_meta_q  <= 1'b0;
            si_sync_q  <= 1'b0;
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 5'd0;
            id_q       <= '0;
            id_ok_q    <= 1'b0;
            active_q   <= DIE_ID_W'(DEF_DIE);
            sel_err_q  <= 1'b0;
        end else begin
            cs_meta_q  <= CS_N;
            cs_sync_q  <= cs_meta_q;
            cs_prev_q  <= cs_sync_q;
            sck_meta_q <= SCK;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
            si_meta_q  <= SI;
            si_sync_q  <= si_meta_q;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            id_q       <= id_d;
            id_ok_q    <= id_ok_d;
            active_q   <= active_d;
            sel_err_q  <= sel_err_d;
        end
    end

    // The chip-select and data-out paths bypass the synchronisers entirely
    always_comb begin
        so_sel = 1'b0;
        for (int i = 0; i < NUM_DIE; i++) begin
            DIE_CS_N[i] = CS_N | (active_q != DIE_ID_W'(i));
            if (active_q == DIE_ID_W'(i)) so_sel = DIE_SO[i];
        end
    end

    assign SO         = CS_N ? 1'bz : so_sel;
    assign ACTIVE_DIE = active_q;
    assign SEL_ERR    = sel_err_q;

`ifdef NAND_DIE_STAT_EN
    logic [15:0] frame_cnt_q [NUM_DIE];
    logic [15:0] frame_cnt_d [NUM_DIE];

    // A frame is credited to the die that was active while it ran
    always_comb begin
        for (int i = 0; i < NUM_DIE; i++) begin
            frame_cnt_d[i] = frame_cnt_q[i];
            if (cs_rise && bit_cnt_q != 5'd0 && active_q == DIE_ID_W'(i) &&
                frame_cnt_q[i] != 16'hFFFF)
                frame_cnt_d[i] = frame_cnt_q[i] + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_DIE; i++) frame_cnt_q[i] <= 16'd0;
        end else begin
            for (int i = 0; i < NUM_DIE; i++) frame_cnt_q[i] <= frame_cnt_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIE; i++) FRAME_CNT[16*i +: 16] = frame_cnt_q[i];
    end
`else
    assign FRAME_CNT = '0;
`endif

endmodule
